// File: rtl/core_writeback_if.sv
// Handshake bundle between the conv core and the feature-map writeback stage.
// The master side drives the frame control and conv results; the slave side returns SRAM writes and status.
interface core_writeback_if;
   logic               i_start;
   logic [1:0]         i_layer_num;
   logic signed [20:0] i_conv;
   logic               o_wen;
   logic [9:0]         o_waddr;
   logic [7:0]         o_wdata;
   logic               o_busy;
   logic               o_done;

   modport master (
      output i_start, i_layer_num, i_conv,
      input  o_wen, o_waddr, o_wdata, o_busy, o_done
   );

   modport slave (
      input  i_start, i_layer_num, i_conv,
      output o_wen, o_waddr, o_wdata, o_busy, o_done
   );
endinterface

// File: rtl/core_writeback.sv
// Writeback stage: tracks the raster position of conv results, selects the positions that produce
// feature-map writes (2x2 pooled or full conv), requantizes them to 8 bits and streams them to the SRAM.
module core_writeback #(
   parameter int IMG_W = 26,
   parameter int DLY   = 2,   // must be at least 1
   parameter int SHIFT = 8
) (
   input  logic            clk,
   input  logic            rst,
   core_writeback_if.slave wb
);

   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int PW = (DLY > 1) ? $clog2(DLY) : 1;
   localparam logic [CW-1:0]        LAST_POS = CW'(IMG_W - 1);
   localparam logic signed [21:0]   ROUND    = 22'(1) << (SHIFT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH
   } state_t;

   state_t          r_state;
   logic            r_is_l2;
   logic [PW-1:0]   r_pre;
   logic [CW-1:0]   r_row;
   logic [CW-1:0]   r_col;
   logic [9:0]      r_wcnt;
   logic            r_wen;
   logic [9:0]      r_waddr;
   logic [7:0]      r_wdata;
   logic            r_busy;
   logic            r_done;

   logic               w_active;
   logic               w_valid;
   logic               w_write;
   logic               w_last;
   logic signed [21:0] w_ext;
   logic signed [21:0] w_relu;
   logic signed [21:0] w_sum;
   logic signed [21:0] w_shr;
   logic [7:0]         w_q;

   // Counter is live once the pre-roll has elapsed; (row-2) odd is the same as row odd.
   assign w_active = (r_state == S_RUN) && (r_pre == '0);
   assign w_valid  = (r_row >= CW'(2)) && (r_col >= CW'(2));
   assign w_write  = w_active && w_valid && (r_is_l2 || (r_row[0] && r_col[0]));
   assign w_last   = (r_row == LAST_POS) && (r_col == LAST_POS);

   // Requantization in 22 bits so the rounding add cannot wrap at the 21-bit extremes.
   always_comb begin
      // NOTE: every combinational output is assigned a default first so no latch is inferred.
      w_q    = 8'h00;
      w_ext  = 22'(wb.i_conv);
      w_relu = w_ext;
      if (!r_is_l2 && w_ext < 0) begin
         w_relu = '0;
      end
      w_sum = w_relu + ROUND;
      w_shr = w_sum >>> SHIFT;
      if (r_is_l2) begin
         if (w_shr > 22'sd127) begin
            w_q = 8'h7F;
         end else if (w_shr < -22'sd128) begin
            w_q = 8'h80;
         end else begin
            w_q = w_shr[7:0];
         end
      end else begin
         if (w_shr > 22'sd255) begin
            w_q = 8'hFF;
         end else begin
            w_q = w_shr[7:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_is_l2 <= 1'b0;
         r_pre   <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_wcnt  <= '0;
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         r_wen  <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (wb.i_start) begin
                  r_state <= S_RUN;
                  r_is_l2 <= (wb.i_layer_num == 2'd2);
                  r_pre   <= PW'(DLY - 1);
                  r_row   <= '0;
                  r_col   <= '0;
                  r_wcnt  <= '0;
                  r_waddr <= '0;
                  r_busy  <= 1'b1;
               end
            end

            S_RUN: begin
               if (r_pre != '0) begin
                  r_pre <= r_pre - PW'(1);
               end else begin
                  if (w_write) begin
                     r_wen   <= 1'b1;
                     r_waddr <= r_wcnt;
                     r_wdata <= w_q;
                     r_wcnt  <= r_wcnt + 10'd1;
                  end
                  if (w_last) begin
                     r_state <= S_FLUSH;
                     r_done  <= 1'b1;
                  end else if (r_col == LAST_POS) begin
                     r_col <= '0;
                     r_row <= r_row + CW'(1);
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end

            S_FLUSH: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign wb.o_wen   = r_wen;
   assign wb.o_waddr = r_waddr;
   assign wb.o_wdata = r_wdata;
   assign wb.o_busy  = r_busy;
   assign wb.o_done  = r_done;

endmodule

// File: tb/tb_core_writeback.sv
// Randomized frame-level bench: a raster/pooling reference model predicts every SRAM write
// (cycle, address, data) plus busy/done, and per-scenario tasks compare the core against it.
module tb_core_writeback;
   localparam int W        = 26;
   localparam int DLY      = 2;
   localparam int SHIFT    = 8;
   localparam int NPIX     = W * W;
   localparam int LAST_CYC = DLY + NPIX;

   logic clk = 1'b0;
   logic rst;

   core_writeback_if bus ();

   core_writeback #(.IMG_W(W), .DLY(DLY), .SHIFT(SHIFT)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_t;

   int checks   = 0;
   int failures = 0;
   int first_wen_cyc;
   int last_writes;
   logic signed [20:0] conv_mem [NPIX];

   // Requantize a conv value from the arithmetic rules: ReLU (pooled layers), round half up, floor-divide, clamp.
   function automatic int ref_q(input int v, input bit l2);
      int x;
      int s;
      int q;
      int div;
      div = 1 << SHIFT;
      x = v;
      if (!l2 && x < 0) x = 0;
      s = x + div / 2;
      q = s / div;
      if (s < 0 && (s % div) != 0) q = q - 1;
      if (l2) begin
         if (q > 127) q = 127;
         if (q < -128) q = -128;
      end else if (q > 255) begin
         q = 255;
      end
      return q & 255;
   endfunction

   task automatic check_idle_outputs(input string tag);
      checks++;
      if (bus.o_wen !== 1'b0 || bus.o_waddr !== 10'd0 || bus.o_wdata !== 8'd0 ||
          bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
         failures++;
         $display("FAIL %s got wen=%0b addr=%0d data=%0h busy=%0b done=%0b exp all zero",
                  tag, bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_busy, bus.o_done);
      end
   endtask

   // Runs one frame from the current negedge. abort_after>=0 resets after that many writes;
   // dup_cycle>=0 pulses a second i_start (with another layer) at that cycle.
   task automatic run_frame(input logic [1:0] layer, input int abort_after, input int dup_cycle);
      wr_t exp_q[$];
      wr_t e;
      int  addr;
      int  nwr;
      bit  l2;
      bit  exp_wen;
      addr = 0;
      nwr  = 0;
      l2   = (layer == 2'd2);
      for (int r = 0; r < W; r++) begin
         for (int c = 0; c < W; c++) begin
            if (r >= 2 && c >= 2 && (l2 || (((r - 2) % 2) == 1 && ((c - 2) % 2) == 1))) begin
               e.cyc  = DLY + r * W + c + 1;
               e.addr = addr;
               e.data = ref_q(int'(conv_mem[r * W + c]), l2);
               exp_q.push_back(e);
               addr++;
            end
         end
      end
      first_wen_cyc = -1;
      bus.i_start     = 1'b1;
      bus.i_layer_num = layer;
      for (int t = 0; t <= LAST_CYC + 2; t++) begin
         int k;
         int cyc;
         k = t - DLY;
         if (k >= 0 && k < NPIX) bus.i_conv = conv_mem[k];
         else bus.i_conv = 21'($urandom);
         if (t == dup_cycle) begin
            bus.i_start     = 1'b1;
            bus.i_layer_num = layer ^ 2'b10;
         end
         @(posedge clk);
         #1;
         bus.i_start = 1'b0;
         @(negedge clk);
         cyc = t + 1;
         exp_wen = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
         checks++;
         if (bus.o_wen !== exp_wen) begin
            failures++;
            $display("FAIL wen cyc=%0d got=%0b exp=%0b", cyc, bus.o_wen, exp_wen);
         end
         if (bus.o_wen === 1'b1 && first_wen_cyc < 0) first_wen_cyc = cyc;
         if (exp_wen) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.o_waddr !== 10'(e.addr)) begin
               failures++;
               $display("FAIL waddr cyc=%0d got=%0d exp=%0d", cyc, bus.o_waddr, e.addr);
            end
            checks++;
            if (bus.o_wdata !== 8'(e.data)) begin
               failures++;
               $display("FAIL wdata cyc=%0d addr=%0d got=%02h exp=%02h", cyc, e.addr, bus.o_wdata, e.data);
            end
            nwr++;
         end
         checks++;
         if (bus.o_done !== (cyc == LAST_CYC)) begin
            failures++;
            $display("FAIL done cyc=%0d got=%0b exp=%0b", cyc, bus.o_done, cyc == LAST_CYC);
         end
         checks++;
         if (bus.o_busy !== (cyc <= LAST_CYC)) begin
            failures++;
            $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, bus.o_busy, cyc <= LAST_CYC);
         end
         if (abort_after >= 0 && nwr == abort_after) begin
            #2 rst = 1'b1;
            #1 check_idle_outputs("abort_reset_immediate");
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               checks++;
               if (bus.o_wen !== 1'b0 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
                  failures++;
                  $display("FAIL abort_quiet got wen=%0b done=%0b busy=%0b exp 0 0 0",
                           bus.o_wen, bus.o_done, bus.o_busy);
               end
            end
            last_writes = nwr;
            return;
         end
      end
      last_writes = nwr;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_writes got=%0d exp=%0d", nwr, nwr + exp_q.size());
      end
   endtask

   task automatic fill_const(input int v);
      for (int k = 0; k < NPIX; k++) conv_mem[k] = 21'(v);
   endtask

   task automatic fill_random();
      for (int k = 0; k < NPIX; k++) begin
         if ($urandom_range(0, 1) == 1) conv_mem[k] = 21'($urandom);
         else conv_mem[k] = 21'(int'($urandom_range(0, 80000)) - 40000);
      end
   endtask

   task automatic check_count(input string tag, input int exp);
      checks++;
      if (last_writes != exp) begin
         failures++;
         $display("FAIL %s write_count got=%0d exp=%0d", tag, last_writes, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_start     = 1'b1;
      bus.i_layer_num = 2'd2;
      bus.i_conv      = '0;
      #1 check_idle_outputs("reset_state");
      @(negedge clk);
      rst = 1'b0;
      bus.i_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.o_busy !== 1'b0 || bus.o_wen !== 1'b0) begin
            failures++;
            $display("FAIL start_during_reset got busy=%0b wen=%0b exp 0 0", bus.o_busy, bus.o_wen);
         end
      end
   endtask

   task automatic test_layer2_const();
      fill_const(256);
      run_frame(2'd2, -1, -1);
      check_count("layer2_const", 576);
   endtask

   task automatic test_layer0_saturation();
      fill_const(-5000);
      run_frame(2'd0, -1, -1);
      check_count("layer0_negative", 144);
      fill_const(32'h0F_FFFF);
      run_frame(2'd0, -1, -1);
      check_count("layer0_saturate", 144);
   endtask

   task automatic test_layer2_rounding();
      int corner [6];
      corner = '{127, 128, -129, -1048576, 1048575, -128};
      for (int k = 0; k < NPIX; k++) conv_mem[k] = 21'(corner[k % 6]);
      run_frame(2'd2, -1, -1);
      check_count("layer2_rounding", 576);
   endtask

   task automatic test_layer1_align();
      for (int k = 0; k < NPIX; k++) conv_mem[k] = 21'(k);
      run_frame(2'd1, -1, -1);
      check_count("layer1_align", 144);
      checks++;
      if (first_wen_cyc != DLY + 3 * W + 3 + 1) begin
         failures++;
         $display("FAIL first_write_cycle got=%0d exp=%0d", first_wen_cyc, DLY + 3 * W + 3 + 1);
      end
   endtask

   task automatic test_random_layers();
      for (int l = 0; l < 4; l++) begin
         fill_random();
         run_frame(2'(l), -1, -1);
         check_count("random_layer", (l == 2) ? 576 : 144);
      end
   endtask

   task automatic test_dup_start();
      fill_random();
      run_frame(2'd2, -1, 300);
      check_count("dup_start", 576);
   endtask

   task automatic test_abort_restart();
      fill_const(256);
      run_frame(2'd2, 100, -1);
      check_count("abort_at_100", 100);
      fill_random();
      run_frame(2'd2, -1, -1);
      check_count("restart_layer2", 576);
      fill_random();
      run_frame(2'd0, -1, -1);
      check_count("restart_layer0", 144);
   endtask

   initial begin
      test_reset();
      test_layer2_const();
      test_layer0_saturation();
      test_layer2_rounding();
      test_layer1_align();
      test_random_layers();
      test_dup_start();
      test_abort_restart();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
